// File: rtl/bpred_pkg.sv
// Shared definitions for the fetch-stage branch predictor: jump codes,
// 2-bit counter states, table entry layout and the PC increment helper.
package bpred_pkg;

   localparam logic [1:0] JC_NONE = 2'b00;
   localparam logic [1:0] JC_BR   = 2'b01;
   localparam logic [1:0] JC_JAL  = 2'b10;
   localparam logic [1:0] JC_JALR = 2'b11;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Tag field sized for the smallest table; narrower tags are zero-extended.
   localparam int TAG_MAX_W = 30;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           ctr;
   } bpred_entry_t;

   localparam bpred_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/f_bpred_if.sv
// Fetch lookup and execute-stage resolution signals of the branch predictor.
interface f_bpred_if;
   logic [31:0] f_pc;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [1:0]  upd_jump_code;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_mispredict;

   modport master (
      output f_pc, upd_valid, upd_pc, upd_jump_code, upd_taken, upd_target, upd_mispredict,
      input  pred_pc, pred_taken
   );

   modport slave (
      input  f_pc, upd_valid, upd_pc, upd_jump_code, upd_taken, upd_target, upd_mispredict,
      output pred_pc, pred_taken
   );
endinterface

// File: rtl/bpred_sat2.sv
// Next state of a 2-bit saturating direction counter.
module bpred_sat2
   import bpred_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_next_o
);

   always_comb begin
      ctr_next_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_next_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SNT) ctr_next_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/f_bpred.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, trained at the clock edge.
// Optional BPRED_STATS_EN adds branch / mispredict counters.
module f_bpred
   import bpred_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int TAG_W = 30 - IDX_W
)(
   input  logic        clk,
   input  logic        rst_n,
   f_bpred_if.slave    bus
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_miss
`endif
);

   localparam int ENTRIES = 1 << IDX_W;

   bpred_entry_t [ENTRIES-1:0] table_rd;

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   bpred_entry_t     f_ent;
   logic             f_hit;

   assign f_idx = bus.f_pc[IDX_W+1:2];
   assign f_tag = bus.f_pc[31:IDX_W+2];
   assign f_ent = table_rd[f_idx];
   assign f_hit = f_ent.valid && (f_ent.tag == TAG_MAX_W'(f_tag));

   assign bus.pred_taken = f_hit & f_ent.ctr[1];
   assign bus.pred_pc    = bus.pred_taken ? f_ent.target : pc_plus4(bus.f_pc);

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   bpred_entry_t     u_ent;
   logic             u_hit;
   logic [1:0]       u_ctr_next;
   logic             wr_en;
   bpred_entry_t     wr_ent;

   assign u_idx = bus.upd_pc[IDX_W+1:2];
   assign u_tag = bus.upd_pc[31:IDX_W+2];
   assign u_ent = table_rd[u_idx];
   assign u_hit = u_ent.valid && (u_ent.tag == TAG_MAX_W'(u_tag));

   bpred_sat2 u_sat2 (
      .ctr_i      (u_ent.ctr),
      .taken_i    (bus.upd_taken),
      .ctr_next_o (u_ctr_next)
   );

   always_comb begin
      wr_en  = 1'b0;
      wr_ent = u_ent;
      if (bus.upd_valid) begin
         case (bus.upd_jump_code)
            JC_JAL, JC_JALR: begin
               wr_en  = 1'b1;
               wr_ent = '{valid: 1'b1, tag: TAG_MAX_W'(u_tag), target: bus.upd_target, ctr: CTR_ST};
            end
            JC_BR: begin
               if (u_hit) begin
                  wr_en      = 1'b1;
                  wr_ent.ctr = u_ctr_next;
                  if (bus.upd_taken) wr_ent.target = bus.upd_target;
               end else if (bus.upd_taken) begin
                  // Taken miss steals the slot from whatever alias lives there.
                  wr_en  = 1'b1;
                  wr_ent = '{valid: 1'b1, tag: TAG_MAX_W'(u_tag), target: bus.upd_target, ctr: CTR_WT};
               end
            end
            default: begin
               if (u_hit) begin
                  wr_en        = 1'b1;
                  wr_ent.valid = 1'b0;
               end
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      bpred_entry_t ent_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            ent_q <= ENTRY_RST;
         else if (wr_en && (u_idx == IDX_W'(gi)))
            ent_q <= wr_ent;
      end

      assign table_rd[gi] = ent_q;
   end

`ifdef BPRED_STATS_EN
   logic [31:0] stat_branches_q;
   logic [31:0] stat_miss_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_q <= '0;
         stat_miss_q     <= '0;
      end else begin
         if (bus.upd_valid && (bus.upd_jump_code != JC_NONE))
            stat_branches_q <= stat_branches_q + 32'd1;
         if (bus.upd_valid && bus.upd_mispredict)
            stat_miss_q <= stat_miss_q + 32'd1;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_miss     = stat_miss_q;

   logic unused_bits;
   assign unused_bits = ^bus.upd_pc[1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{bus.upd_pc[1:0], bus.upd_mispredict};
`endif

endmodule

// File: tb/tb_f_bpred.sv
// Scoreboard bench for f_bpred: expected predictions queued as stimulus is driven,
// popped and compared mid-cycle. Stats checks run when BPRED_STATS_EN is defined.
module tb_f_bpred;
   import bpred_pkg::*;

   localparam logic [31:0] IDLE_PC = 32'h0000_080C;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   f_bpred_if bus ();

`ifdef BPRED_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_miss;
`endif

   f_bpred dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef BPRED_STATS_EN
      ,
      .stat_branches (stat_branches),
      .stat_miss     (stat_miss)
`endif
   );

   typedef struct {
      string       tag;
      logic        taken;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic taken, input logic [31:0] pc);
      exp_t e;
      e.tag   = tag;
      e.taken = taken;
      e.pc    = pc;
      sb_q.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         $display("%-16s f_pc=%h pred_taken=%b pred_pc=%h", e.tag, bus.f_pc, bus.pred_taken, bus.pred_pc);
         chk({e.tag, ".taken"}, 32'(bus.pred_taken), 32'(e.taken));
         chk({e.tag, ".pc"}, bus.pred_pc, e.pc);
      end
   endtask

   task automatic cyc(input string tag, input logic [31:0] fpc, input logic etaken, input logic [31:0] epc,
                      input logic uv, input logic [31:0] upc, input logic [1:0] jc, input logic ut,
                      input logic [31:0] utgt, input logic um);
      @(posedge clk);
      #1;
      bus.f_pc           = fpc;
      bus.upd_valid      = uv;
      bus.upd_pc         = upc;
      bus.upd_jump_code  = jc;
      bus.upd_taken      = ut;
      bus.upd_target     = utgt;
      bus.upd_mispredict = um;
      push_exp(tag, etaken, epc);
      @(negedge clk);
      sample();
   endtask

   task automatic look(input string tag, input logic [31:0] fpc, input logic etaken, input logic [31:0] epc);
      cyc(tag, fpc, etaken, epc, 1'b0, 32'h0, JC_NONE, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic upd(input string tag, input logic [31:0] upc, input logic [1:0] jc, input logic ut,
                      input logic [31:0] utgt, input logic um);
      cyc(tag, IDLE_PC, 1'b0, IDLE_PC + 32'd4, 1'b1, upc, jc, ut, utgt, um);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n              = 1'b0;
      bus.f_pc           = 32'h100;
      bus.upd_valid      = 1'b0;
      bus.upd_pc         = 32'h0;
      bus.upd_jump_code  = JC_NONE;
      bus.upd_taken      = 1'b0;
      bus.upd_target     = 32'h0;
      bus.upd_mispredict = 1'b0;

      #2;
      push_exp("rst_100", 1'b0, 32'h104);
      sample();
      bus.f_pc = 32'hFFFF_FFFC;
      #1;
      push_exp("rst_wrap", 1'b0, 32'h0);
      sample();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // JAL training, wrap, same-cycle update with no bypass
      upd ("jal_100",     32'h100, JC_JAL, 1'b1, 32'h200, 1'b1);
      look("jal_hit",     32'h100, 1'b1, 32'h200);
      look("wrap",        32'hFFFF_FFFC, 1'b0, 32'h0);
      cyc ("same_old",    32'h100, 1'b1, 32'h200, 1'b1, 32'h100, JC_JALR, 1'b1, 32'h300, 1'b0);
      look("same_new",    32'h100, 1'b1, 32'h300);

      // Updates that must not write
      upd ("none_miss",   32'h140, JC_NONE, 1'b0, 32'h0, 1'b0);
      look("keep_a",      32'h100, 1'b1, 32'h300);
      upd ("br_nt_miss",  32'h140, JC_BR, 1'b0, 32'h999, 1'b0);
      look("keep_b",      32'h100, 1'b1, 32'h300);
      cyc ("upd_invalid", IDLE_PC, 1'b0, IDLE_PC + 32'd4, 1'b0, 32'h100, JC_NONE, 1'b0, 32'h0, 1'b0);
      look("keep_c",      32'h100, 1'b1, 32'h300);

      // Alias on index 0, then invalidate by jump_code 00 hit
      look("alias_140",   32'h140, 1'b0, 32'h144);
      upd ("inv_100",     32'h100, JC_NONE, 1'b0, 32'h0, 1'b0);
      look("inv_look",    32'h100, 1'b0, 32'h104);

      // Conditional branch at 0x40: allocate at 10, walk down, saturate at 00, climb, saturate at 11
      upd ("br_alloc",    32'h40, JC_BR, 1'b1, 32'h80, 1'b0);
      look("br_10",       32'h40, 1'b1, 32'h80);
      upd ("br_nt1",      32'h40, JC_BR, 1'b0, 32'h0, 1'b1);
      look("br_01",       32'h40, 1'b0, 32'h44);
      upd ("br_nt2",      32'h40, JC_BR, 1'b0, 32'h0, 1'b0);
      look("br_00",       32'h40, 1'b0, 32'h44);
      upd ("br_nt3",      32'h40, JC_BR, 1'b0, 32'h0, 1'b0);
      upd ("br_t1",       32'h40, JC_BR, 1'b1, 32'h80, 1'b0);
      look("br_sat_lo",   32'h40, 1'b0, 32'h44);
      upd ("br_t2",       32'h40, JC_BR, 1'b1, 32'h88, 1'b1);
      look("br_newtgt",   32'h40, 1'b1, 32'h88);
      upd ("br_t3",       32'h40, JC_BR, 1'b1, 32'h88, 1'b0);
      upd ("br_t4",       32'h40, JC_BR, 1'b1, 32'h88, 1'b0);
      upd ("br_nt4",      32'h40, JC_BR, 1'b0, 32'h0, 1'b0);
      look("br_sat_hi",   32'h40, 1'b1, 32'h88);
      upd ("br_nt5",      32'h40, JC_BR, 1'b0, 32'h0, 1'b0);
      look("br_back_01",  32'h40, 1'b0, 32'h44);

      // JAL over a weak branch forces counter to 11
      upd ("jal_40",      32'h40, JC_JAL, 1'b1, 32'h90, 1'b0);
      look("jal_40_hit",  32'h40, 1'b1, 32'h90);
      upd ("jal_40_nt",   32'h40, JC_BR, 1'b0, 32'h0, 1'b0);
      look("jal_40_10",   32'h40, 1'b1, 32'h90);

      // Asynchronous reset mid-training with an update in flight
      @(posedge clk);
      #1;
      bus.f_pc          = 32'h40;
      bus.upd_valid     = 1'b1;
      bus.upd_pc        = 32'h40;
      bus.upd_jump_code = JC_JAL;
      bus.upd_taken     = 1'b1;
      bus.upd_target    = 32'hA0;
      #2 rst_n = 1'b0;
      #1;
      push_exp("mid_rst", 1'b0, 32'h44);
      sample();
      @(posedge clk);
      #1;
      bus.upd_valid = 1'b0;
      rst_n = 1'b1;
      look("after_rst",   32'h40, 1'b0, 32'h44);

`ifdef BPRED_STATS_EN
      chk("stat_br_rst",   stat_branches, 32'd0);
      chk("stat_miss_rst", stat_miss, 32'd0);
      upd ("st_br",       32'h40, JC_BR, 1'b1, 32'h80, 1'b0);
      upd ("st_jal",      32'h140, JC_JAL, 1'b1, 32'h300, 1'b1);
      upd ("st_jalr",     32'h240, JC_JALR, 1'b1, 32'h400, 1'b0);
      cyc ("st_novalid",  IDLE_PC, 1'b0, IDLE_PC + 32'd4, 1'b0, 32'h40, JC_BR, 1'b0, 32'h0, 1'b1);
      upd ("st_none",     32'h500, JC_NONE, 1'b0, 32'h0, 1'b0);
      look("st_settle",   32'h240, 1'b1, 32'h400);
      chk("stat_br_cnt",   stat_branches, 32'd3);
      chk("stat_miss_cnt", stat_miss, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("stat_br_clr",   stat_branches, 32'd0);
      chk("stat_miss_clr", stat_miss, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
`endif

      if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/f_bpred.md
# f_bpred

Fetch-stage branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters per entry. Each cycle it supplies the predicted next PC for the instruction being fetched, which travels down the pipeline as `pc_predicted`. The execute stage later returns the resolved outcome and target, and the predictor trains on it.

## Interface
Parameters:
- IDX_W, 4: index width; table has 2^IDX_W entries, index = pc[IDX_W+1:2]
- TAG_W, 30-IDX_W: tag width, tag = pc[31:IDX_W+2]

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_pc  in  32  PC of instruction in fetch
- pred_pc  out  32  predicted next PC for f_pc
- pred_taken  out  1  1 = prediction redirects to the stored target
- upd_valid  in  1  execute-stage resolution valid (0 on bubbles and flushed slots)
- upd_pc  in  32  PC of the resolved instruction
- upd_jump_code  in  2  00 none, 01 conditional branch, 10 JAL, 11 JALR
- upd_taken  in  1  resolved direction (1 for JAL/JALR)
- upd_target  in  32  resolved next PC when taken
- upd_mispredict  in  1  execute-stage prediction-miss flag, used for statistics only

## Operation
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Lookup (combinational from registered table): hit = valid & tag match; pred_taken = hit & ctr[1]; pred_pc = pred_taken ? target : f_pc + 4. The add wraps modulo 2^32.
- Update applies only when upd_valid = 1 and is written at the clock edge. Index and tag come from upd_pc.
- jump_code 10/11:
  - Write valid = 1, tag, target = upd_target and ctr = 11, whether the lookup hits or misses.
- jump_code 01, hit:
  - ctr increments if taken and decrements if not taken, saturating at 11 and 00.
  - If taken, target is overwritten with upd_target.
- jump_code 01, miss:
  - If taken, allocate (overwriting any alias) with ctr = 10.
  - If not taken, no write.
- jump_code 00, hit: invalidate the entry (valid = 0). This covers aliasing and stale entries.
- jump_code 00, miss: no write.
- Lookup and update of the same index in the same cycle: lookup sees pre-update contents, with no bypass.
- The counter moves on every resolved branch, whether or not upd_mispredict is set.

## Timing
- Lookup latency: 0 cycles, combinational from f_pc.
- Update visible to lookup from the cycle after the update edge.
- Reset, asynchronous: all valid = 0, ctr = 01, target = 0, tag = 0.
  - Outputs immediately become pred_taken = 0, pred_pc = f_pc + 4.
  - Reset asserted mid-training discards all entries, and any update in flight is lost.
- With rst_n high and upd_valid = 0, state holds.

## Configuration
- BPRED_STATS_EN defined: adds outputs stat_branches[32] and stat_miss[32].
  - stat_branches increments on each upd_valid with jump_code != 00.
  - stat_miss increments on each upd_valid & upd_mispredict.
  - Both counters wrap at 2^32, reset to 0, and read as registered values.
- BPRED_STATS_EN undefined: the ports and counters are absent, and prediction behaviour is identical.

## Structure
- Shared package `bpred_pkg`:
  - jump-code constants JC_NONE/JC_BR/JC_JAL/JC_JALR, matching the execute-stage encoding
  - counter constants CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11
  - entry typedef
- One sub-module, `bpred_sat2`: combinational 2-bit saturating counter next-state (ctr, taken -> ctr_next).

## Test plan
- Reset, then f_pc = 0x100 -> pred_taken = 0, pred_pc = 0x104. Likewise f_pc = 0xFFFFFFFC -> pred_pc = 0x00000000.
- JAL update upd_pc = 0x100, upd_target = 0x200; next cycle f_pc = 0x100 -> pred_taken = 1, pred_pc = 0x200.
- Branch at 0x40 with target 0x80, resolved taken, then not-taken twice:
  - f_pc = 0x40 gives pred_pc = 0x80, then 0x44, then 0x44; ctr reaches 00.
  - A further not-taken keeps ctr at 00.
- Alias with IDX_W = 4: JAL at 0x100 (target 0x300), then f_pc = 0x140 (same index, different tag) -> pred_pc = 0x144.
  - Then update jump_code 00 at 0x100 -> f_pc = 0x100 gives 0x104.
- Same-cycle update and lookup of 0x100 -> that cycle predicts from old contents; the following cycle uses new contents.
- BPRED_STATS_EN: 3 branch updates, one with upd_mispredict = 1, plus one update with upd_valid = 0 -> stat_branches = 3, stat_miss = 1.
  - Assert rst_n low mid-sequence -> both counters 0 immediately.
